wc_in_loader: RTL

Input-side loader that sits directly upstream of the `WC_5_3` Winograd core, between the input pad buffers and the core. It accepts a serial stream of 10-bit words and assembles:
- one 3x3 kernel (9 words) after every reset or reload;
- a stream of 5x5 input tiles (25 words each).

Each completed tile is presented to the core as a parallel, double-buffered snapshot, so the next tile loads while the core consumes the current one.

---
 rtl/wc_pkg.sv | 19 +
 rtl/wc_in_loader_if.sv | 24 ++
 rtl/wc_word_buf.sv | 29 ++
 rtl/wc_in_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/wc_pkg.sv
// rtl/wc_pkg.sv - shared constants and load-state type for the wc_in_loader slice
// Holds word/kernel/tile sizes, index and tile-counter widths, terminal index
// values and the loader state enum.
package wc_pkg;
    localparam int DW    = 10;
    localparam int KN    = 9;
    localparam int TN    = 25;
    localparam int IDX_W = 5;
    localparam int CNT_W = 16;

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(KN - 1);
    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(TN - 1);

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_X = 2'd1,
        FULL   = 2'd2
    } load_state_t;
endpackage

// File: rtl/wc_in_loader_if.sv
// rtl/wc_in_loader_if.sv - word stream in, tile snapshot out
// Ports: in_valid/in_data/in_ready (word stream into the loader),
//        x_flat/tile_valid/tile_ready (tile hold buffer towards the core).
// slave is the loader side, master is the upstream/core side.
interface wc_in_loader_if;
    import wc_pkg::*;

    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic [TN*DW-1:0] x_flat;
    logic             tile_valid;
    logic             tile_ready;

    modport slave (
        input  in_valid, in_data, tile_ready,
        output in_ready, x_flat, tile_valid
    );

    modport master (
        output in_valid, in_data, tile_ready,
        input  in_ready, x_flat, tile_valid
    );
endinterface

// File: rtl/wc_word_buf.sv
// rtl/wc_word_buf.sv - indexed register bank with flattened output
// Ports: clk, rst (async active-low clear), we (write enable), idx (slot),
//        din (word), flat (all N slots, slot k at flat[k*DW +: DW]).
module wc_word_buf #(
    parameter int N  = 9,
    parameter int DW = 10,
    parameter int IW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [IW-1:0]   idx,
    input  logic [DW-1:0]   din,
    output logic [N*DW-1:0] flat
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flat <= '0;
        end else if (we) begin
            for (int k = 0; k < N; k++) begin
                if (idx == IW'(k)) begin
                    flat[k*DW +: DW] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/wc_in_loader.sv
// rtl/wc_in_loader.sv - kernel/tile loader feeding the WC_5_3 Winograd core
// Ports: clk, rst (async active-low), ld (word stream in, tile hold buffer out),
//        w_reload (kernel reload request), w_flat (3x3 kernel), w_loaded
//        (kernel complete), tile_cnt (tiles handed to the core, wrapping).
module wc_in_loader
    import wc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wc_in_loader_if.slave        ld,
    input  logic                 w_reload,
    output logic [KN*DW-1:0]     w_flat,
    output logic                 w_loaded,
    output logic [CNT_W-1:0]     tile_cnt
);

    load_state_t      state_q, state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [IDX_W-1:0] x_idx_q, x_idx_d;
    logic             w_loaded_d;

    logic             accept;
    logic             tile_hs;
    logic             hold_free;
    logic             kernel_we;
    logic             fill_we;
    logic             copy;
    logic [TN*DW-1:0] fill_flat;
    logic [TN*DW-1:0] copy_data;

    assign ld.in_ready = (state_q != FULL);
    assign accept      = ld.in_valid && ld.in_ready;
    assign tile_hs     = ld.tile_valid && ld.tile_ready;
    // The hold buffer can take a new tile if it is empty or is being consumed now.
    assign hold_free   = !ld.tile_valid || ld.tile_ready;

    // On the last-word edge the fill bank has not yet captured word 24, so
    // the snapshot takes it straight from the input bus.
    assign copy_data = (state_q == FULL) ? fill_flat
                                         : {ld.in_data, fill_flat[(TN-1)*DW-1:0]};

    wc_word_buf #(.N(KN), .DW(DW), .IW(IDX_W)) u_kernel_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (kernel_we),
        .idx  (w_idx_q),
        .din  (ld.in_data),
        .flat (w_flat)
    );

    wc_word_buf #(.N(TN), .DW(DW), .IW(IDX_W)) u_fill_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (fill_we),
        .idx  (x_idx_q),
        .din  (ld.in_data),
        .flat (fill_flat)
    );

    always_comb begin
        state_d    = state_q;
        w_idx_d    = w_idx_q;
        x_idx_d    = x_idx_q;
        w_loaded_d = w_loaded;
        kernel_we  = 1'b0;
        fill_we    = 1'b0;
        copy       = 1'b0;

        case (state_q)
            LOAD_W: begin
                if (accept) begin
                    kernel_we = 1'b1;
                    if (w_idx_q == K_LAST) begin
                        w_idx_d    = '0;
                        w_loaded_d = 1'b1;
                        state_d    = LOAD_X;
                    end else begin
                        w_idx_d = w_idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD_X: begin
                // Reload only between tiles; a word offered in the same cycle
                // is dropped rather than landing in either bank.
                if (w_reload && (x_idx_q == '0)) begin
                    w_loaded_d = 1'b0;
                    w_idx_d    = '0;
                    state_d    = LOAD_W;
                end else if (accept) begin
                    fill_we = 1'b1;
                    if (x_idx_q == T_LAST) begin
                        if (hold_free) begin
                            copy    = 1'b1;
                            x_idx_d = '0;
                        end else begin
                            state_d = FULL;
                        end
                    end else begin
                        x_idx_d = x_idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                // Index stays parked at its terminal value until the release.
                if (tile_hs) begin
                    copy    = 1'b1;
                    x_idx_d = '0;
                    state_d = LOAD_X;
                end
            end
            default: begin
                state_d = LOAD_W;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD_W;
            w_idx_q  <= '0;
            x_idx_q  <= '0;
            w_loaded <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_idx_q  <= w_idx_d;
            x_idx_q  <= x_idx_d;
            w_loaded <= w_loaded_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld.x_flat     <= '0;
            ld.tile_valid <= 1'b0;
            tile_cnt      <= '0;
        end else begin
            if (copy) begin
                ld.x_flat <= copy_data;
            end
            if (copy) begin
                ld.tile_valid <= 1'b1;
            end else if (tile_hs) begin
                ld.tile_valid <= 1'b0;
            end
            if (tile_hs) begin
                tile_cnt <= tile_cnt + 1'b1;
            end
        end
    end

endmodule
